// File: rtl/shift_operator.sv
`default_nettype none
// ============================================================================
// Module   : shift_operator
// Purpose  : Registered 32-bit barrel shifter for the ALU shift path of the
//            multi-cycle MIPS datapath. Shifts operand B by shamt using a
//            five-stage log-depth mux network (1,2,4,8,16) followed by one
//            output register: one-cycle latency, valid strobe alongside.
// Ports    : clk        rising-edge clock
//            rst_n      asynchronous active-low reset
//            in_valid   capture strobe (op/B/shamt sampled on this edge)
//            op         00 SLL, 01 SRL, 10 SRA, 11 ROR or SRL (see macro)
//            B          operand to shift
//            shamt      shift amount 0..31
//            res        registered shift result
//            out_valid  high for one cycle when res was updated
// Config   : SHIFT_OPERATOR_ROR_EN
//              defined   -> op=11 rotates right
//              undefined -> no rotate logic, op=11 behaves as SRL
// Revision : 1.0 - initial release
// ============================================================================
module shift_operator #(
  parameter int WIDTH = 32,                   // must be 32 (5-bit shamt)
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   B,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   res,
  output logic               out_valid
);

  localparam logic [1:0] c_OP_SLL = 2'b00;
  localparam logic [1:0] c_OP_SRA = 2'b10;
`ifdef SHIFT_OPERATOR_ROR_EN
  localparam logic [1:0] c_OP_ROR = 2'b11;
`endif

  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic             out_valid_q;

  logic             w_right;
  logic             w_fill;
  logic             w_rot;
  logic [WIDTH-1:0] w_net;
  logic [WIDTH-1:0] w_lo;

  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

  // Only a left-shift network is built. Right shifts/rotates reverse the
  // operand on the way in and out, so one network serves every op.
  always_comb begin
    w_right = (op != c_OP_SLL);
    w_fill  = (op == c_OP_SRA) & B[WIDTH-1];
`ifdef SHIFT_OPERATOR_ROR_EN
    w_rot   = (op == c_OP_ROR);
`else
    w_rot   = 1'b0;
`endif
    w_lo    = '0;
    w_net   = w_right ? bitrev(B) : B;
    for (int k = 0; k < SHAMT_W; k++) begin
      if (shamt[k]) begin
        // Bits entering at the LSB end: the bits falling off the top for a
        // rotate, otherwise the fill bit (sign for SRA, zero elsewhere).
        w_lo  = w_rot ? (w_net >> (WIDTH - (1 << k)))
                      : ({WIDTH{w_fill}} & ~({WIDTH{1'b1}} << (1 << k)));
        w_net = (w_net << (1 << k)) | w_lo;
      end
    end
    res_d = w_right ? bitrev(w_net) : w_net;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        res_q <= res_d;
      end
    end
  end

  assign res       = res_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_operator.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_operator
// Purpose  : Self-checking bench for shift_operator. Directed table of
//            hand-computed vectors, hand-written reset / idle / back-to-back
//            sequences, and a short run of random vectors against an
//            operator-level reference model. Honours SHIFT_OPERATOR_ROR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_operator;

`ifdef SHIFT_OPERATOR_ROR_EN
  localparam bit c_ROR = 1'b1;
`else
  localparam bit c_ROR = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  op;
  logic [31:0] B;
  logic [4:0]  shamt;
  logic [31:0] res;
  logic        out_valid;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  localparam int c_NVEC = 22;
  vec_t tbl [c_NVEC];

  shift_operator u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .op        (op),
    .B         (B),
    .shamt     (shamt),
    .res       (res),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] b,
                                            input logic [4:0] s);
    case (o)
      2'b00: return b << s;
      2'b01: return b >> s;
      2'b10: return $unsigned($signed(b) >>> s);
      default: begin
        if (c_ROR) return (s == 5'd0) ? b : ((b >> s) | (b << (6'd32 - {1'b0, s})));
        else       return b >> s;
      end
    endcase
  endfunction

  // Present one op on the falling edge; check result just after the next rise.
  task automatic apply(input string name, input logic [1:0] o, input logic [31:0] b,
                       input logic [4:0] s, input logic [31:0] exp);
    @(negedge clk);
    in_valid = 1'b1;
    op       = o;
    B        = b;
    shamt    = s;
    @(posedge clk);
    #1;
    check({name, ".res"}, res, exp);
    check({name, ".valid"}, {31'b0, out_valid}, 32'h1);
  endtask

  initial begin
    logic [31:0] last;
    logic [1:0]  ro;
    logic [31:0] rb;
    logic [4:0]  rs;

    tbl[0]  = '{2'b00, 32'h80000000, 5'd3,  32'h00000000};
    tbl[1]  = '{2'b01, 32'h80000000, 5'd3,  32'h10000000};
    tbl[2]  = '{2'b10, 32'h80000000, 5'd3,  32'hF0000000};
    tbl[3]  = '{2'b11, 32'h80000000, 5'd3,  32'h10000000};
    tbl[4]  = '{2'b00, 32'h12345678, 5'd0,  32'h12345678};
    tbl[5]  = '{2'b01, 32'h12345678, 5'd0,  32'h12345678};
    tbl[6]  = '{2'b10, 32'h12345678, 5'd0,  32'h12345678};
    tbl[7]  = '{2'b11, 32'h12345678, 5'd0,  32'h12345678};
    tbl[8]  = '{2'b10, 32'h7FFFFFFF, 5'd31, 32'h00000000};
    tbl[9]  = '{2'b00, 32'h00000001, 5'd31, 32'h80000000};
    tbl[10] = '{2'b01, 32'h80000000, 5'd31, 32'h00000001};
    tbl[11] = '{2'b10, 32'h80000000, 5'd31, 32'hFFFFFFFF};
    tbl[12] = '{2'b11, 32'h80000001, 5'd3,  c_ROR ? 32'h30000000 : 32'h10000000};
    tbl[13] = '{2'b00, 32'h12345678, 5'd4,  32'h23456780};
    tbl[14] = '{2'b01, 32'h12345678, 5'd4,  32'h01234567};
    tbl[15] = '{2'b10, 32'h87654321, 5'd4,  32'hF8765432};
    tbl[16] = '{2'b10, 32'h87654321, 5'd16, 32'hFFFF8765};
    tbl[17] = '{2'b11, 32'h12345678, 5'd8,  c_ROR ? 32'h78123456 : 32'h00123456};
    tbl[18] = '{2'b00, 32'hDEADBEEF, 5'd16, 32'hBEEF0000};
    tbl[19] = '{2'b01, 32'hDEADBEEF, 5'd1,  32'h6F56DF77};
    tbl[20] = '{2'b10, 32'hDEADBEEF, 5'd1,  32'hEF56DF77};
    tbl[21] = '{2'b11, 32'hDEADBEEF, 5'd31, c_ROR ? 32'hBD5B7DDF : 32'h00000001};

    // Reset state and quiet release.
    rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; B = '0; shamt = '0;
    #12;
    check("reset.res", res, 32'h0);
    check("reset.valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_reset.res", res, 32'h0);
    check("idle_after_reset.valid", {31'b0, out_valid}, 32'h0);

    // Table vectors, applied back-to-back.
    for (int i = 0; i < c_NVEC; i++) begin
      apply($sformatf("vec%0d", i), tbl[i].op, tbl[i].b, tbl[i].sh, tbl[i].exp);
    end
    last = tbl[c_NVEC-1].exp;

    // Idle: result holds, valid drops, even with inputs wiggling.
    @(negedge clk);
    in_valid = 1'b0; op = 2'b00; B = 32'hFFFFFFFF; shamt = 5'd1;
    @(posedge clk); #1;
    check("idle_hold.res", res, last);
    check("idle_hold.valid", {31'b0, out_valid}, 32'h0);
    @(posedge clk); #1;
    check("idle_hold2.res", res, last);

    // Four consecutive captures, then idle.
    apply("b2b0", 2'b00, 32'h0000000F, 5'd2,  32'h0000003C);
    apply("b2b1", 2'b01, 32'hF0000000, 5'd8,  32'h00F00000);
    apply("b2b2", 2'b10, 32'hC0000000, 5'd30, 32'hFFFFFFFF);
    apply("b2b3", 2'b00, 32'hA5A5A5A5, 5'd31, 32'h80000000);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_idle.res", res, 32'h80000000);
    check("b2b_idle.valid", {31'b0, out_valid}, 32'h0);

    // Asynchronous reset mid-cycle, with an op offered during reset.
    apply("pre_rst", 2'b00, 32'h00000003, 5'd4, 32'h00000030);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.res", res, 32'h0);
    check("async_rst.valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    in_valid = 1'b1; op = 2'b00; B = 32'h12345678; shamt = 5'd0;
    @(posedge clk); #1;
    check("in_rst_discard.res", res, 32'h0);
    check("in_rst_discard.valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst.res", res, 32'h0);
    check("post_rst.valid", {31'b0, out_valid}, 32'h0);
    apply("first_after_rst", 2'b10, 32'h80000000, 5'd3, 32'hF0000000);

    // Random vectors against the reference model.
    for (int i = 0; i < 300; i++) begin
      ro = 2'($urandom_range(0, 3));
      rb = $urandom;
      rs = 5'($urandom_range(0, 31));
      apply($sformatf("rnd%0d", i), ro, rb, rs, ref_model(ro, rb, rs));
    end
    @(negedge clk); in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
